// File: rtl/ycbcr_pkg.sv
// Shared colour-conversion constants and types for both RGB<->YCbCr directions.
package ycbcr_pkg;

  localparam int FRAC_BITS     = 8;
  localparam int ROUND         = 128;
  localparam int CHROMA_OFFSET = 128;

  // Forward set (RGB -> YCbCr), rows Y / Cb / Cr, columns R / G / B
  localparam int FWD_Y_R  = 77;
  localparam int FWD_Y_G  = 150;
  localparam int FWD_Y_B  = 29;
  localparam int FWD_CB_R = -43;
  localparam int FWD_CB_G = -85;
  localparam int FWD_CB_B = 128;
  localparam int FWD_CR_R = 128;
  localparam int FWD_CR_G = -107;
  localparam int FWD_CR_B = -21;

  // Inverse set (YCbCr -> RGB); the G terms are subtracted
  localparam int INV_CR_R = 359;
  localparam int INV_CB_G = 88;
  localparam int INV_CR_G = 183;
  localparam int INV_CB_B = 454;

  localparam logic [1:0] COMP_R  = 2'd0;
  localparam logic [1:0] COMP_G  = 2'd1;
  localparam logic [1:0] COMP_B  = 2'd2;
  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  typedef enum logic [1:0] {
    PH_Y  = 2'd0,
    PH_CB = 2'd1,
    PH_CR = 2'd2
  } in_phase_e;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_EMIT_R,
    OUT_EMIT_G,
    OUT_EMIT_B
  } out_phase_e;

endpackage

// File: rtl/ycbcr_to_rgb_stage_1_if.sv
// Byte-serial YCbCr in / RGB out stream bundle for the inverse converter.
interface ycbcr_to_rgb_stage_1_if;
  logic       valid_i;
  logic       first_i;
  logic [7:0] ycc_data_i;
  logic       valid_o;
  logic [1:0] status_o;
  logic [7:0] rgb_data_o;
  logic       misalign_o;
  logic [1:0] in_phase_o;

  modport slave (
    input  valid_i, first_i, ycc_data_i,
    output valid_o, status_o, rgb_data_o, misalign_o, in_phase_o
  );

  modport master (
    output valid_i, first_i, ycc_data_i,
    input  valid_o, status_o, rgb_data_o, misalign_o, in_phase_o
  );
endinterface

// File: rtl/ycbcr_to_rgb_stage_1_sat_u8.sv
// Clamp a 19-bit signed colour sum into the unsigned 0..255 byte range.
module sat_u8 (
  input  logic signed [18:0] sum_i,
  output logic        [7:0]  data_o
);

  always_comb begin
    if (sum_i[18]) begin
      data_o = '0;
    end else if (|sum_i[17:8]) begin
      data_o = '1;
    end else begin
      data_o = sum_i[7:0];
    end
  end

endmodule

// File: rtl/ycbcr_to_rgb_stage_1.sv
// Byte-serial YCbCr -> RGB converter: collects Y/Cb/Cr, converts on Cr,
// and replays R/G/B one per cycle starting on the Cr edge.
module ycbcr_to_rgb_stage_1
  import ycbcr_pkg::*;
#(
  parameter int COEF_CR_R = INV_CR_R,
  parameter int COEF_CB_G = INV_CB_G,
  parameter int COEF_CR_G = INV_CR_G,
  parameter int COEF_CB_B = INV_CB_B
) (
  input logic                   clk,
  input logic                   rst_n,
  ycbcr_to_rgb_stage_1_if.slave bus
);

  localparam logic signed [18:0] K_CR_R = 19'(COEF_CR_R);
  localparam logic signed [18:0] K_CB_G = 19'(COEF_CB_G);
  localparam logic signed [18:0] K_CR_G = 19'(COEF_CR_G);
  localparam logic signed [18:0] K_CB_B = 19'(COEF_CB_B);
  localparam logic signed [18:0] K_RND  = 19'(ROUND);
  localparam logic signed [18:0] K_OFS  = 19'(CHROMA_OFFSET);

  in_phase_e         in_phase_q, in_phase_d;
  out_phase_e        state_q, state_d;
  logic [7:0]        y_q, y_d, cb_q, cb_d;
  logic [2:0][7:0]   rgb_q, rgb_d;
  logic [1:0]        status_q, status_d;
  logic              misalign_q, misalign_d;
  logic              convert;

  logic signed [18:0] y_s, cb_s, cr_s, r_sum, g_sum, b_sum;
  logic        [7:0]  r_u8, g_u8, b_u8;
  logic        [7:0]  rgb_data;

  // Input phase tracking; first_i always restarts a triplet with this byte as Y
  always_comb begin
    in_phase_d = in_phase_q;
    y_d        = y_q;
    cb_d       = cb_q;
    misalign_d = 1'b0;
    convert    = 1'b0;
    if (bus.valid_i) begin
      if (bus.first_i) begin
        y_d        = bus.ycc_data_i;
        in_phase_d = PH_CB;
        misalign_d = (in_phase_q != PH_Y);
      end else begin
        case (in_phase_q)
          PH_Y: begin
            y_d        = bus.ycc_data_i;
            in_phase_d = PH_CB;
          end
          PH_CB: begin
            cb_d       = bus.ycc_data_i;
            in_phase_d = PH_CR;
          end
          default: begin
            convert    = 1'b1;
            in_phase_d = PH_Y;
          end
        endcase
      end
    end
  end

  // Arithmetic uses the live Cr byte so R is ready on the Cr edge
  always_comb begin
    y_s   = $signed({11'b0, y_q});
    cb_s  = $signed({11'b0, cb_q}) - K_OFS;
    cr_s  = $signed({11'b0, bus.ycc_data_i}) - K_OFS;
    r_sum = y_s + ((K_CR_R * cr_s + K_RND) >>> FRAC_BITS);
    g_sum = y_s + ((-(K_CB_G * cb_s) - K_CR_G * cr_s + K_RND) >>> FRAC_BITS);
    b_sum = y_s + ((K_CB_B * cb_s + K_RND) >>> FRAC_BITS);
  end

  sat_u8 u_sat_r (.sum_i(r_sum), .data_o(r_u8));
  sat_u8 u_sat_g (.sum_i(g_sum), .data_o(g_u8));
  sat_u8 u_sat_b (.sum_i(b_sum), .data_o(b_u8));

  always_comb begin
    rgb_d = rgb_q;
    if (convert) begin
      rgb_d[0] = r_u8;
      rgb_d[1] = g_u8;
      rgb_d[2] = b_u8;
    end
  end

  // A new Cr always restarts at R; it can only land in EMIT_B or IDLE
  always_comb begin
    state_d = state_q;
    if (convert) begin
      state_d = OUT_EMIT_R;
    end else begin
      case (state_q)
        OUT_EMIT_R: state_d = OUT_EMIT_G;
        OUT_EMIT_G: state_d = OUT_EMIT_B;
        default:    state_d = OUT_IDLE;
      endcase
    end
  end

  always_comb begin
    status_d = status_q;
    case (state_d)
      OUT_EMIT_R: status_d = COMP_R;
      OUT_EMIT_G: status_d = COMP_G;
      OUT_EMIT_B: status_d = COMP_B;
      default:    status_d = status_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_phase_q <= PH_Y;
      state_q    <= OUT_IDLE;
      y_q        <= '0;
      cb_q       <= '0;
      rgb_q      <= '0;
      status_q   <= COMP_R;
      misalign_q <= 1'b0;
    end else begin
      in_phase_q <= in_phase_d;
      state_q    <= state_d;
      y_q        <= y_d;
      cb_q       <= cb_d;
      rgb_q      <= rgb_d;
      status_q   <= status_d;
      misalign_q <= misalign_d;
    end
  end

  // Data follows the held status, so it also holds while valid_o is low
  always_comb begin
    case (status_q)
      COMP_G:  rgb_data = rgb_q[1];
      COMP_B:  rgb_data = rgb_q[2];
      default: rgb_data = rgb_q[0];
    endcase
  end

  assign bus.valid_o    = (state_q != OUT_IDLE);
  assign bus.status_o   = status_q;
  assign bus.rgb_data_o = rgb_data;
  assign bus.misalign_o = misalign_q;
  assign bus.in_phase_o = in_phase_q;

endmodule

// File: tb/tb_ycbcr_to_rgb_stage_1.sv
// Directed bench for the byte-serial YCbCr -> RGB converter.
module tb_ycbcr_to_rgb_stage_1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ycbcr_to_rgb_stage_1_if bus ();

  ycbcr_to_rgb_stage_1 #(
    .COEF_CR_R(359),
    .COEF_CB_G(88),
    .COEF_CR_G(183),
    .COEF_CB_B(454)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one input cycle, then check outputs just after the edge
  task automatic cyc(input string tag, input logic v, input logic f, input logic [7:0] d,
                     input logic ev, input logic [1:0] es, input logic [7:0] ed,
                     input logic em);
    bus.valid_i    = v;
    bus.first_i    = f;
    bus.ycc_data_i = d;
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'(ev));
    chk({tag, ".misalign"}, 32'(bus.misalign_o), 32'(em));
    if (ev) begin
      chk({tag, ".status"}, 32'(bus.status_o), 32'(es));
      chk({tag, ".data"}, 32'(bus.rgb_data_o), 32'(ed));
    end
  endtask

  initial begin
    bus.valid_i    = 1'b0;
    bus.first_i    = 1'b0;
    bus.ycc_data_i = 8'd0;

    #12;
    chk("rst.valid", 32'(bus.valid_o), 32'd0);
    chk("rst.status", 32'(bus.status_o), 32'd0);
    chk("rst.data", 32'(bus.rgb_data_o), 32'd0);
    chk("rst.misalign", 32'(bus.misalign_o), 32'd0);
    chk("rst.phase", 32'(bus.in_phase_o), 32'd0);
    rst_n = 1'b1;

    // Mid-grey
    cyc("grey.y",  1, 1, 8'd128, 0, 0, 0, 0);
    cyc("grey.cb", 1, 0, 8'd128, 0, 0, 0, 0);
    cyc("grey.r",  1, 0, 8'd128, 1, 0, 8'd128, 0);
    cyc("grey.g",  0, 0, 8'd0,   1, 1, 8'd128, 0);
    cyc("grey.b",  0, 0, 8'd0,   1, 2, 8'd128, 0);
    cyc("grey.end", 0, 0, 8'd0,  0, 0, 0, 0);
    chk("grey.hold_status", 32'(bus.status_o), 32'd2);
    chk("grey.hold_data", 32'(bus.rgb_data_o), 32'd128);

    // Rounding path, G = 76 + floor(-75.5)
    cyc("rnd.y",  1, 1, 8'd76,  0, 0, 0, 0);
    cyc("rnd.cb", 1, 0, 8'd85,  0, 0, 0, 0);
    cyc("rnd.r",  1, 0, 8'd255, 1, 0, 8'd254, 0);
    cyc("rnd.g",  0, 0, 8'd0,   1, 1, 8'd0, 0);
    cyc("rnd.b",  0, 0, 8'd0,   1, 2, 8'd0, 0);
    cyc("rnd.end", 0, 0, 8'd0,  0, 0, 0, 0);

    // Two clamping pixels with no gaps: six consecutive output bytes
    cyc("b2b.y0",  1, 1, 8'd0,   0, 0, 0, 0);
    cyc("b2b.cb0", 1, 0, 8'd255, 0, 0, 0, 0);
    cyc("b2b.r0",  1, 0, 8'd0,   1, 0, 8'd0, 0);
    cyc("b2b.g0",  1, 1, 8'd255, 1, 1, 8'd48, 0);
    cyc("b2b.b0",  1, 0, 8'd128, 1, 2, 8'd225, 0);
    cyc("b2b.r1",  1, 0, 8'd255, 1, 0, 8'd255, 0);
    cyc("b2b.g1",  0, 0, 8'd0,   1, 1, 8'd164, 0);
    cyc("b2b.b1",  0, 0, 8'd0,   1, 2, 8'd255, 0);
    cyc("b2b.end", 0, 0, 8'd0,   0, 0, 0, 0);

    // Gaps between input bytes hold the phase
    cyc("gap.y",   1, 1, 8'd150, 0, 0, 0, 0);
    cyc("gap.g1",  0, 0, 8'd77,  0, 0, 0, 0);
    chk("gap.phase1", 32'(bus.in_phase_o), 32'd1);
    cyc("gap.cb",  1, 0, 8'd100, 0, 0, 0, 0);
    cyc("gap.g2",  0, 0, 8'd33,  0, 0, 0, 0);
    chk("gap.phase2", 32'(bus.in_phase_o), 32'd2);
    cyc("gap.r",   1, 0, 8'd180, 1, 0, 8'd223, 0);
    cyc("gap.g",   0, 0, 8'd0,   1, 1, 8'd122, 0);
    cyc("gap.b",   0, 0, 8'd0,   1, 2, 8'd100, 0);
    cyc("gap.end", 0, 0, 8'd0,   0, 0, 0, 0);

    // Realignment: first_i in the Cr slot discards the partial triplet
    cyc("mis.y",   1, 1, 8'd10,  0, 0, 0, 0);
    cyc("mis.cb",  1, 0, 8'd20,  0, 0, 0, 0);
    cyc("mis.fy",  1, 1, 8'd128, 0, 0, 0, 1);
    chk("mis.phase", 32'(bus.in_phase_o), 32'd1);
    cyc("mis.cb2", 1, 0, 8'd128, 0, 0, 0, 0);
    cyc("mis.r",   1, 0, 8'd128, 1, 0, 8'd128, 0);
    cyc("mis.g",   0, 0, 8'd0,   1, 1, 8'd128, 0);
    cyc("mis.b",   0, 0, 8'd0,   1, 2, 8'd128, 0);
    cyc("mis.end", 0, 0, 8'd0,   0, 0, 0, 0);

    // Reset between Cb and Cr
    cyc("ra.y",  1, 1, 8'd200, 0, 0, 0, 0);
    cyc("ra.cb", 1, 0, 8'd50,  0, 0, 0, 0);
    bus.valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ra.valid", 32'(bus.valid_o), 32'd0);
    chk("ra.phase", 32'(bus.in_phase_o), 32'd0);
    rst_n = 1'b1;
    cyc("ra.y2",  1, 1, 8'd128, 0, 0, 0, 0);
    cyc("ra.cb2", 1, 0, 8'd128, 0, 0, 0, 0);
    cyc("ra.r",   1, 0, 8'd128, 1, 0, 8'd128, 0);
    cyc("ra.g",   0, 0, 8'd0,   1, 1, 8'd128, 0);
    cyc("ra.b",   0, 0, 8'd0,   1, 2, 8'd128, 0);
    cyc("ra.end", 0, 0, 8'd0,   0, 0, 0, 0);

    // Reset during EMIT_G
    cyc("rb.y",  1, 1, 8'd76,  0, 0, 0, 0);
    cyc("rb.cb", 1, 0, 8'd85,  0, 0, 0, 0);
    cyc("rb.r",  1, 0, 8'd255, 1, 0, 8'd254, 0);
    cyc("rb.g",  0, 0, 8'd0,   1, 1, 8'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rb.valid", 32'(bus.valid_o), 32'd0);
    chk("rb.phase", 32'(bus.in_phase_o), 32'd0);
    rst_n = 1'b1;
    cyc("rb.y2",  1, 1, 8'd150, 0, 0, 0, 0);
    cyc("rb.cb2", 1, 0, 8'd100, 0, 0, 0, 0);
    cyc("rb.r2",  1, 0, 8'd180, 1, 0, 8'd223, 0);
    cyc("rb.g2",  0, 0, 8'd0,   1, 1, 8'd122, 0);
    cyc("rb.b2",  0, 0, 8'd0,   1, 2, 8'd100, 0);
    cyc("rb.end", 0, 0, 8'd0,   0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
